pipelined_control_unit: RTL and testbench

//  Pipelined successor to the single-cycle main decoder. Decodes the ID-stage opcode, carries the

---
 rtl/mips_ctrl_pkg.sv | 64 ++++++
 rtl/control_decode.sv | 69 ++++++
 rtl/pipelined_control_unit.sv | 100 ++++++++++
 tb/tb_pipelined_control_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Purpose: shared opcode, ALUOp and memory-size encodings plus the packed per-stage control bundles.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_ctrl_pkg;

    // Opcodes (6-bit ISA field)
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_MUL   = 6'b011100;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // ALUOp codes (native 4-bit, zero-extended at the port)
    localparam logic [3:0] ALU_ADDR  = 4'b0000;  // load/store address add
    localparam logic [3:0] ALU_ADDI  = 4'b0001;
    localparam logic [3:0] ALU_RTYPE = 4'b0010;  // funct field selects the op
    localparam logic [3:0] ALU_AND   = 4'b1010;
    localparam logic [3:0] ALU_OR    = 4'b1011;
    localparam logic [3:0] ALU_XOR   = 4'b1100;
    localparam logic [3:0] ALU_SLT   = 4'b1101;
    localparam logic [3:0] ALU_MUL   = 4'b1111;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } mem_size_e;

    typedef struct packed {
        logic       reg_dst;
        logic [3:0] alu_op;
        logic       alu_src;
        logic       illegal;
    } ex_ctrl_t;

    typedef struct packed {
        logic      mem_read;
        logic      mem_write;
        mem_size_e size;
    } mem_ctrl_t;

    typedef struct packed {
        logic mem_to_reg;
        logic reg_write;
    } wb_ctrl_t;

    typedef struct packed {
        ex_ctrl_t  ex;
        mem_ctrl_t mem;
        wb_ctrl_t  wb;
    } ctrl_t;

    // Bubble: every control bit clear, including illegal.
    localparam ctrl_t BUBBLE = '0;

endpackage

// File: rtl/control_decode.sv
// Purpose: combinational opcode -> control bundle, illegal flag and "reads rt" flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; consumer decides whether to use the result.
// Ports: opcode_i (ID opcode) -> ctrl_o (full control bundle), uses_rt_o (rt is a source operand).
module control_decode
    import mips_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter bit EN_MUL   = 1'b1
) (
    input  logic [OPCODE_W-1:0] opcode_i,
    output ctrl_t               ctrl_o,
    output logic                uses_rt_o
);

    always_comb begin
        ctrl_o    = BUBBLE;
        uses_rt_o = 1'b0;
        case (opcode_i)
            OPCODE_W'(OP_RTYPE): begin
                ctrl_o.ex.reg_dst   = 1'b1;
                ctrl_o.ex.alu_op    = ALU_RTYPE;
                ctrl_o.wb.reg_write = 1'b1;
                uses_rt_o           = 1'b1;
            end
            OPCODE_W'(OP_ADDI), OPCODE_W'(OP_ANDI), OPCODE_W'(OP_ORI),
            OPCODE_W'(OP_XORI), OPCODE_W'(OP_SLTI): begin
                ctrl_o.ex.alu_src   = 1'b1;
                ctrl_o.wb.reg_write = 1'b1;
                case (opcode_i)
                    OPCODE_W'(OP_ADDI): ctrl_o.ex.alu_op = ALU_ADDI;
                    OPCODE_W'(OP_ANDI): ctrl_o.ex.alu_op = ALU_AND;
                    OPCODE_W'(OP_ORI):  ctrl_o.ex.alu_op = ALU_OR;
                    OPCODE_W'(OP_XORI): ctrl_o.ex.alu_op = ALU_XOR;
                    default:            ctrl_o.ex.alu_op = ALU_SLT;
                endcase
            end
            OPCODE_W'(OP_LW), OPCODE_W'(OP_LH), OPCODE_W'(OP_LB): begin
                ctrl_o.ex.alu_src    = 1'b1;
                ctrl_o.ex.alu_op     = ALU_ADDR;
                ctrl_o.mem.mem_read  = 1'b1;
                ctrl_o.wb.mem_to_reg = 1'b1;
                ctrl_o.wb.reg_write  = 1'b1;
                ctrl_o.mem.size      = (opcode_i == OPCODE_W'(OP_LW)) ? SZ_WORD :
                                       (opcode_i == OPCODE_W'(OP_LH)) ? SZ_HALF : SZ_BYTE;
            end
            OPCODE_W'(OP_SW), OPCODE_W'(OP_SH), OPCODE_W'(OP_SB): begin
                ctrl_o.ex.alu_src    = 1'b1;
                ctrl_o.ex.alu_op     = ALU_ADDR;
                ctrl_o.mem.mem_write = 1'b1;
                uses_rt_o            = 1'b1;  // rt supplies the store data
                ctrl_o.mem.size      = (opcode_i == OPCODE_W'(OP_SW)) ? SZ_WORD :
                                       (opcode_i == OPCODE_W'(OP_SH)) ? SZ_HALF : SZ_BYTE;
            end
            OPCODE_W'(OP_MUL): begin
                if (EN_MUL) begin
                    ctrl_o.ex.reg_dst   = 1'b1;
                    ctrl_o.ex.alu_op    = ALU_MUL;
                    ctrl_o.wb.reg_write = 1'b1;
                    uses_rt_o           = 1'b1;
                end else begin
                    ctrl_o.ex.illegal = 1'b1;
                end
            end
            default: ctrl_o.ex.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipelined_control_unit.sv
// Purpose: decode ID opcode and carry controls through ID/EX, EX/MEM, MEM/WB with load-use stall and flush.
// Latency: Ex* 1 cycle, Mem* 2 cycles, Wb* 3 cycles after the opcode is in ID.
// Backpressure: Stall (combinational) holds PC and IF/ID for one cycle per load-use hazard; EX onward never stalls.
// Ports: Clk/Rst (sync active-low); ID inputs IDValid, InstCode, IDRs, IDRt, Flush;
//        outputs Stall plus registered Ex*, Mem*, Wb* control fields for the datapath.
module pipelined_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 4,
    parameter int REG_W    = 5,
    parameter bit EN_MUL   = 1'b1
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                IDValid,
    input  logic [OPCODE_W-1:0] InstCode,
    input  logic [REG_W-1:0]    IDRs,
    input  logic [REG_W-1:0]    IDRt,
    input  logic                Flush,
    output logic                Stall,
    output logic                ExRegDst,
    output logic [ALUOP_W-1:0]  ExALUOp,
    output logic                ExALUSrc,
    output logic                ExIllegal,
    output logic                MemMemRead,
    output logic                MemMemWrite,
    output logic [1:0]          MemSize,
    output logic                WbMemToReg,
    output logic                WbRegWrite
);

    ctrl_t             dec_ctrl;
    logic              dec_uses_rt;

    ctrl_t             id_ex_q,  id_ex_d;
    logic [REG_W-1:0]  ex_rt_q,  ex_rt_d;
    logic              ex_vld_q, ex_vld_d;
    mem_ctrl_t         ex_mem_mem_q;
    wb_ctrl_t          ex_mem_wb_q;
    wb_ctrl_t          mem_wb_q;

    logic              load_use;

    control_decode #(
        .OPCODE_W (OPCODE_W),
        .EN_MUL   (EN_MUL)
    ) u_decode (
        .opcode_i  (InstCode),
        .ctrl_o    (dec_ctrl),
        .uses_rt_o (dec_uses_rt)
    );

    // A load to $zero never produces a value worth waiting for.
    assign load_use = ex_vld_q & id_ex_q.mem.mem_read & (ex_rt_q != '0) &
                      ((ex_rt_q == IDRs) | (dec_uses_rt & (ex_rt_q == IDRt)));

    // Flush suppresses the stall: the redirected instruction is dropped anyway.
    assign Stall = IDValid & ~Flush & load_use;

    always_comb begin
        id_ex_d  = BUBBLE;
        ex_rt_d  = '0;
        ex_vld_d = 1'b0;
        if (IDValid && !Flush && !Stall) begin
            id_ex_d  = dec_ctrl;
            ex_rt_d  = IDRt;
            ex_vld_d = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            id_ex_q      <= BUBBLE;
            ex_rt_q      <= '0;
            ex_vld_q     <= 1'b0;
            ex_mem_mem_q <= BUBBLE.mem;
            ex_mem_wb_q  <= BUBBLE.wb;
            mem_wb_q     <= BUBBLE.wb;
        end else begin
            id_ex_q      <= id_ex_d;
            ex_rt_q      <= ex_rt_d;
            ex_vld_q     <= ex_vld_d;
            ex_mem_mem_q <= id_ex_q.mem;
            ex_mem_wb_q  <= id_ex_q.wb;
            mem_wb_q     <= ex_mem_wb_q;
        end
    end

    assign ExRegDst    = id_ex_q.ex.reg_dst;
    assign ExALUOp     = ALUOP_W'(id_ex_q.ex.alu_op);  // upper bits zero when ALUOP_W > 4
    assign ExALUSrc    = id_ex_q.ex.alu_src;
    assign ExIllegal   = id_ex_q.ex.illegal;
    assign MemMemRead  = ex_mem_mem_q.mem_read;
    assign MemMemWrite = ex_mem_mem_q.mem_write;
    assign MemSize     = ex_mem_mem_q.size;
    assign WbMemToReg  = mem_wb_q.mem_to_reg;
    assign WbRegWrite  = mem_wb_q.reg_write;

endmodule

// File: tb/tb_pipelined_control_unit.sv
module tb_pipelined_control_unit;

    logic       Clk = 1'b0;
    logic       Rst, IDValid, Flush;
    logic [5:0] InstCode;
    logic [4:0] IDRs, IDRt;
    logic       Stall, ExRegDst, ExALUSrc, ExIllegal;
    logic [3:0] ExALUOp;
    logic       MemMemRead, MemMemWrite, WbMemToReg, WbRegWrite;
    logic [1:0] MemSize;

    always #5 Clk = ~Clk;

    pipelined_control_unit dut (
        .Clk(Clk), .Rst(Rst), .IDValid(IDValid), .InstCode(InstCode),
        .IDRs(IDRs), .IDRt(IDRt), .Flush(Flush), .Stall(Stall),
        .ExRegDst(ExRegDst), .ExALUOp(ExALUOp), .ExALUSrc(ExALUSrc), .ExIllegal(ExIllegal),
        .MemMemRead(MemMemRead), .MemMemWrite(MemMemWrite), .MemSize(MemSize),
        .WbMemToReg(WbMemToReg), .WbRegWrite(WbRegWrite)
    );

    // One instruction occupying a pipeline stage in the reference model.
    typedef struct {
        bit         v;
        logic [5:0] op;
        logic [4:0] rt;
    } slot_t;

    typedef struct packed {
        logic       stall;
        logic       reg_dst;
        logic [3:0] alu_op;
        logic       alu_src;
        logic       illegal;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] size;
        logic       mem_to_reg;
        logic       reg_write;
    } obs_t;

    obs_t  exp_q[$];
    slot_t m_ex, m_mem, m_wb;
    int    n_chk  = 0;
    int    n_fail = 0;
    int    cyc    = 0;
    bit    last_stall = 1'b0;

    function automatic bit is_load(logic [5:0] op);
        return op inside {6'b100011, 6'b100001, 6'b100000};
    endfunction

    function automatic bit is_store(logic [5:0] op);
        return op inside {6'b101011, 6'b101001, 6'b101000};
    endfunction

    function automatic bit uses_rt(logic [5:0] op);
        return (op == 6'b000000) || (op == 6'b011100) || is_store(op);
    endfunction

    // Control table for an instruction that is really present in a stage.
    function automatic obs_t ref_ctrl(logic [5:0] op);
        obs_t o = '0;
        if (op == 6'b000000) begin
            o.reg_dst = 1; o.alu_op = 4'b0010; o.reg_write = 1;
        end else if (op == 6'b011100) begin
            o.reg_dst = 1; o.alu_op = 4'b1111; o.reg_write = 1;
        end else if (is_load(op) || is_store(op)) begin
            o.alu_src    = 1;
            o.mem_read   = is_load(op);
            o.mem_to_reg = is_load(op);
            o.reg_write  = is_load(op);
            o.mem_write  = is_store(op);
            // low opcode bits 11/01/00 select word/half/byte
            o.size = (op[1:0] == 2'b11) ? 2'b10 : op[1:0];
        end else if (op inside {6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010}) begin
            o.alu_src = 1; o.reg_write = 1;
            case (op)
                6'b001000: o.alu_op = 4'b0001;
                6'b001100: o.alu_op = 4'b1010;
                6'b001101: o.alu_op = 4'b1011;
                6'b001110: o.alu_op = 4'b1100;
                default:   o.alu_op = 4'b1101;
            endcase
        end else begin
            o.illegal = 1;
        end
        return o;
    endfunction

    task automatic chk(string nm, logic [3:0] act, logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Drive one ID-stage cycle, record the outputs expected during it, then advance the model.
    task automatic drive(input bit rst, input bit vld, input logic [5:0] op,
                         input logic [4:0] rs, input logic [4:0] rt, input bit fl);
        obs_t e, c;
        bit   st;
        @(negedge Clk);
        cyc++;
        Rst = rst; IDValid = vld; InstCode = op; IDRs = rs; IDRt = rt; Flush = fl;
        st = vld && !fl && m_ex.v && is_load(m_ex.op) && (m_ex.rt != 0) &&
             ((m_ex.rt == rs) || (uses_rt(op) && (m_ex.rt == rt)));
        e = '0;
        e.stall = st;
        if (m_ex.v) begin
            c = ref_ctrl(m_ex.op);
            e.reg_dst = c.reg_dst; e.alu_op = c.alu_op;
            e.alu_src = c.alu_src; e.illegal = c.illegal;
        end
        if (m_mem.v) begin
            c = ref_ctrl(m_mem.op);
            e.mem_read = c.mem_read; e.mem_write = c.mem_write; e.size = c.size;
        end
        if (m_wb.v) begin
            c = ref_ctrl(m_wb.op);
            e.mem_to_reg = c.mem_to_reg; e.reg_write = c.reg_write;
        end
        exp_q.push_back(e);
        last_stall = st;
        if (!rst) begin
            m_ex.v = 0; m_mem.v = 0; m_wb.v = 0;
        end else begin
            m_wb  = m_mem;
            m_mem = m_ex;
            m_ex.v  = vld && !fl && !st;
            m_ex.op = op;
            m_ex.rt = rt;
        end
    endtask

    // Monitor: compares every cycle for which the stimulus posted an expectation.
    always @(negedge Clk) begin
        obs_t e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("Stall",       {3'b0, Stall},       {3'b0, e.stall});
            chk("ExRegDst",    {3'b0, ExRegDst},    {3'b0, e.reg_dst});
            chk("ExALUOp",     ExALUOp,             e.alu_op);
            chk("ExALUSrc",    {3'b0, ExALUSrc},    {3'b0, e.alu_src});
            chk("ExIllegal",   {3'b0, ExIllegal},   {3'b0, e.illegal});
            chk("MemMemRead",  {3'b0, MemMemRead},  {3'b0, e.mem_read});
            chk("MemMemWrite", {3'b0, MemMemWrite}, {3'b0, e.mem_write});
            chk("MemSize",     {2'b0, MemSize},     {2'b0, e.size});
            chk("WbMemToReg",  {3'b0, WbMemToReg},  {3'b0, e.mem_to_reg});
            chk("WbRegWrite",  {3'b0, WbRegWrite},  {3'b0, e.reg_write});
        end
    end

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, SH = 6'b101001;
    localparam logic [5:0] ADD = 6'b000000, ADDI = 6'b001000, BAD = 6'b111111;

    initial begin
        logic [5:0] ops [14];
        logic [5:0] r_op;
        logic [4:0] r_rs, r_rt;
        bit         r_vld, r_fl, r_rst;

        ops = '{6'h00, 6'h08, 6'h23, 6'h21, 6'h20, 6'h2b, 6'h29, 6'h28,
                6'h0c, 6'h0d, 6'h0e, 6'h0a, 6'h1c, 6'h3f};
        m_ex.v = 0; m_mem.v = 0; m_wb.v = 0;
        Rst = 0; IDValid = 0; InstCode = 0; IDRs = 0; IDRt = 0; Flush = 0;
        @(posedge Clk);

        // reset state
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        // load-use on rs: one stall, then add issues
        drive(1, 1, LW,  0, 9, 0);
        drive(1, 1, ADD, 9, 3, 0);
        drive(1, 1, ADD, 9, 3, 0);
        repeat (3) drive(1, 0, 0, 0, 0, 0);
        // addi only writes rt: no stall
        drive(1, 1, LW,   0, 9, 0);
        drive(1, 1, ADDI, 4, 9, 0);
        repeat (3) drive(1, 0, 0, 0, 0, 0);
        // load to $zero: no stall
        drive(1, 1, LW,  1, 0, 0);
        drive(1, 1, ADD, 0, 0, 0);
        repeat (3) drive(1, 0, 0, 0, 0, 0);
        // sh: MemWrite + half size, no RegWrite
        drive(1, 1, SH, 2, 3, 0);
        repeat (3) drive(1, 0, 0, 0, 0, 0);
        // hazard with flush, then illegal opcode
        drive(1, 1, LW,  0, 9, 0);
        drive(1, 1, ADD, 9, 9, 1);
        drive(1, 1, BAD, 1, 2, 0);
        repeat (3) drive(1, 0, 0, 0, 0, 0);
        // reset with lw in MEM and sw in EX
        drive(1, 1, LW, 1, 5, 0);
        drive(1, 1, SW, 1, 6, 0);
        drive(0, 0, 0, 0, 0, 0);
        repeat (4) drive(1, 0, 0, 0, 0, 0);

        // randomized traffic; IF/ID is held while Stall is asserted
        r_op = 0; r_rs = 0; r_rt = 0; r_vld = 0; r_fl = 0; r_rst = 1;
        for (int i = 0; i < 600; i++) begin
            if (!last_stall) begin
                r_rst = ($urandom_range(0, 49) != 0);
                r_vld = ($urandom_range(0, 7) != 0);
                r_fl  = ($urandom_range(0, 7) == 0);
                r_op  = ($urandom_range(0, 4) == 0) ? 6'($urandom) : ops[$urandom_range(0, 13)];
                r_rs  = 5'($urandom_range(0, 3));
                r_rt  = 5'($urandom_range(0, 3));
            end
            drive(r_rst, r_vld, r_op, r_rs, r_rt, r_fl);
        end
        repeat (4) drive(1, 0, 0, 0, 0, 0);

        @(negedge Clk);
        #5;
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
